// File: rtl/s4ga_pkg.sv
// rtl/s4ga_pkg.sv - shared types, default geometry and helpers for the S4GA config streamer
package s4ga_pkg;

   // Streamer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Default fabric geometry: 16 LUTs of 4 inputs, 32 config bits per LUT
   localparam int DEF_N        = 16;
   localparam int DEF_K        = 4;
   localparam int DEF_SI_W     = 4;
   localparam int DEF_WORD_W   = 16;
   localparam int DEF_CFG_BITS = DEF_N * 32;

   // Derived framing for the default geometry
   localparam int NIB_PER_WORD    = DEF_WORD_W / DEF_SI_W;
   localparam int WORDS_PER_FRAME = DEF_CFG_BITS / DEF_WORD_W;

   // A word must split into whole nibbles and a frame into whole words
   function automatic bit geometry_ok(input int si_w, input int word_w, input int cfg_bits);
      return (si_w > 0) && (word_w >= si_w) && ((word_w % si_w) == 0) &&
             (cfg_bits >= word_w) && ((cfg_bits % word_w) == 0);
   endfunction

   // Counter width for a range of n values, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam bit DEF_GEOMETRY_OK = geometry_ok(DEF_SI_W, DEF_WORD_W, DEF_CFG_BITS);

endpackage

// File: rtl/s4ga_piso.sv
// rtl/s4ga_piso.sv - parallel-in serial-out register shifting right STEP bits per cycle
module s4ga_piso #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic [STEP-1:0]  q
);

   logic [WIDTH-1:0] sreg;

   // Load takes priority so a back-to-back word replaces the drained one without a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= data;
      end else if (shift) begin
         sreg <= sreg >> STEP;
      end
   end

   assign q = sreg[STEP-1:0];

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// rtl/s4ga_cfg_streamer.sv - frames one configuration bitstream onto the S4GA serial config bus
module s4ga_cfg_streamer
   import s4ga_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int K        = DEF_K,
   parameter int SI_W     = DEF_SI_W,
   parameter int WORD_W   = DEF_WORD_W,
   parameter int CFG_BITS = N * 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic [SI_W-1:0]   si,
   output logic              si_en,
   output logic              busy,
   output logic              done,
   output logic              underrun
);

   localparam int NPW   = WORD_W / SI_W;
   localparam int WPF   = CFG_BITS / WORD_W;
   localparam int NIB_W = cnt_width(NPW);
   localparam int WRD_W = cnt_width(WPF);

   localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NPW - 1);
   localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(WPF - 1);
   localparam logic             NIB_ONE  = 1'(NPW == 1);

   if (!geometry_ok(SI_W, WORD_W, CFG_BITS) || (K < 1)) begin : g_bad_geometry
      $error("s4ga_cfg_streamer: WORD_W must be a multiple of SI_W and CFG_BITS a multiple of WORD_W");
   end

   state_e           state;
   logic [NIB_W-1:0] nib_cnt;
   logic [WRD_W-1:0] word_cnt;
   logic             handshake;
   logic             last_nib;
   logic             last_word;
   logic [SI_W-1:0]  piso_q;

   assign handshake = word_valid && word_ready;
   assign last_nib  = (nib_cnt == NIB_LAST);
   assign last_word = (word_cnt == WRD_LAST);

   s4ga_piso #(
      .WIDTH (WORD_W),
      .STEP  (SI_W)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (handshake),
      .shift (state == ST_SHIFT),
      .data  (word_in),
      .q     (piso_q)
   );

   // The bus is forced quiet whenever no nibble is being presented
   assign si = si_en ? piso_q : '0;

   // Frame control: counters track the word being shifted and the nibble on si
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         nib_cnt    <= '0;
         word_cnt   <= '0;
         word_ready <= 1'b0;
         si_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_LOAD;
                  nib_cnt    <= '0;
                  word_cnt   <= '0;
                  word_ready <= 1'b1;
                  si_en      <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  underrun   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (handshake) begin
                  state      <= ST_SHIFT;
                  nib_cnt    <= '0;
                  si_en      <= 1'b1;
                  word_ready <= NIB_ONE && !last_word;
               end
            end
            ST_SHIFT: begin
               if (!last_nib) begin
                  nib_cnt    <= nib_cnt + 1'b1;
                  word_ready <= ((nib_cnt + 1'b1) == NIB_LAST) && !last_word;
               end else if (last_word) begin
                  state      <= ST_DONE;
                  nib_cnt    <= '0;
                  si_en      <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  word_ready <= 1'b0;
               end else if (handshake) begin
                  word_cnt   <= word_cnt + 1'b1;
                  nib_cnt    <= '0;
                  word_ready <= NIB_ONE && ((word_cnt + 1'b1) != WRD_LAST);
               end else begin
                  state      <= ST_LOAD;
                  word_cnt   <= word_cnt + 1'b1;
                  nib_cnt    <= '0;
                  si_en      <= 1'b0;
                  word_ready <= 1'b1;
                  underrun   <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
